// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcodes, field widths, beat layouts and width helpers
// used by the link buffer, its per-channel queue and the bench.
package tl_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    localparam int OPCODE_W  = 3;
    localparam int A_PARAM_W = 3;
    localparam int D_PARAM_W = 2;
    localparam int SIZE_W    = 3;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_SRC_W  = 1;

    // Beat layouts for the default widths; the top rebuilds these with its own parameters.
    typedef struct packed {
        logic [OPCODE_W-1:0]     opcode;
        logic [A_PARAM_W-1:0]    param;
        logic [SIZE_W-1:0]       size;
        logic [DEF_SRC_W-1:0]    source;
        logic [DEF_ADDR_W-1:0]   address;
        logic [DEF_DATA_W/8-1:0] mask;
        logic [DEF_DATA_W-1:0]   data;
    } tl_a_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [D_PARAM_W-1:0]  param;
        logic [SIZE_W-1:0]     size;
        logic [DEF_SRC_W-1:0]  source;
        logic                  denied;
        logic [DEF_DATA_W-1:0] data;
        logic                  corrupt;
    } tl_d_t;

    function automatic int a_w(int addr_w, int data_w, int src_w);
        return OPCODE_W + A_PARAM_W + SIZE_W + src_w + addr_w + data_w / 8 + data_w;
    endfunction

    function automatic int d_w(int data_w, int src_w);
        return OPCODE_W + D_PARAM_W + SIZE_W + src_w + 1 + data_w + 1;
    endfunction

    // A zero-depth queue still exposes a one-bit count tied to zero.
    function automatic int count_width(int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/tl_link_buffer_if.sv
// One TileLink channel (valid/ready/bits) between a producer and a consumer.
interface tl_link_buffer_if #(
    parameter int WIDTH = 1
);
    // Handshake: the master drives valid and bits, the slave drives ready. A beat moves on a
    // rising clock edge where valid & ready; once valid is high it stays high with bits
    // unchanged until that edge, and ready may depend combinationally on valid.
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] bits;

    modport master (output valid, output bits, input ready);
    modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/tl_queue.sv
// Single-channel FIFO stage with optional flow-through and pipelined-full behaviour;
// a depth of zero reduces it to wires.
module tl_queue
    import tl_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    parameter bit FLOW  = 1'b0,
    parameter bit PIPE  = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    tl_link_buffer_if.slave               enq,
    tl_link_buffer_if.master              deq,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    generate
        if (DEPTH == 0) begin : g_wire
            assign deq.valid = enq.valid;
            assign deq.bits  = enq.bits;
            assign enq.ready = deq.ready;
            assign count     = '0;
        end else begin : g_fifo
            localparam int             PW       = ptr_width(DEPTH);
            localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
            localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

            logic [WIDTH-1:0] mem [DEPTH];
            logic [PW-1:0]    rptr;
            logic [PW-1:0]    wptr;
            logic [CW-1:0]    cnt;
            logic             empty;
            logic             full;
            logic             enq_fire;
            logic             deq_fire;
            logic             bypass;
            logic             do_enq;
            logic             do_deq;

            assign empty = (cnt == '0);
            assign full  = (cnt == FULL_CNT);

            // Reset masks the output side and keeps the input side ready so nothing stalls.
            assign deq.valid = !reset && (!empty || (FLOW && enq.valid));
            assign deq.bits  = (FLOW && empty) ? enq.bits : mem[rptr];
            assign enq.ready = reset || !full || (PIPE && deq.ready);

            always_comb begin
                enq_fire = enq.valid && enq.ready;
                deq_fire = deq.valid && deq.ready;
                // A flow-through beat that leaves immediately never touches storage.
                bypass   = FLOW && empty && enq_fire && deq_fire;
                do_enq   = enq_fire && !bypass && !reset;
                do_deq   = deq_fire && !bypass;
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    rptr <= '0;
                    wptr <= '0;
                    cnt  <= '0;
                end else begin
                    if (do_enq) wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
                    if (do_deq) rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
                    if (do_enq && !do_deq) begin
                        cnt <= cnt + 1'b1;
                    end else if (!do_enq && do_deq) begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end

            // Payload storage carries no reset; only the pointers and count define validity.
            always_ff @(posedge clock) begin
                if (do_enq) mem[wptr] <= enq.bits;
            end

            assign count = cnt;
        end
    endgenerate

endmodule

// File: rtl/tl_link_buffer.sv
// TileLink-UL link buffer: an independent tl_queue on the A (request) and D (response)
// channels; this level only unpacks, repacks and wires the beats.
module tl_link_buffer
    import tl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 1,
    parameter int A_DEPTH = 2,
    parameter int D_DEPTH = 2,
    parameter bit A_FLOW  = 1'b0,
    parameter bit D_FLOW  = 1'b0,
    parameter bit A_PIPE  = 1'b0,
    parameter bit D_PIPE  = 1'b0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_a_valid,
    output logic                                  in_a_ready,
    input  logic [a_w(ADDR_W, DATA_W, SRC_W)-1:0] in_a_bits,
    output logic                                  out_a_valid,
    input  logic                                  out_a_ready,
    output logic [a_w(ADDR_W, DATA_W, SRC_W)-1:0] out_a_bits,
    input  logic                                  in_d_valid,
    output logic                                  in_d_ready,
    input  logic [d_w(DATA_W, SRC_W)-1:0]         in_d_bits,
    output logic                                  out_d_valid,
    input  logic                                  out_d_ready,
    output logic [d_w(DATA_W, SRC_W)-1:0]         out_d_bits,
    output logic [count_width(A_DEPTH)-1:0]       a_count,
    output logic [count_width(D_DEPTH)-1:0]       d_count
);

    localparam int A_W = a_w(ADDR_W, DATA_W, SRC_W);
    localparam int D_W = d_w(DATA_W, SRC_W);

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [A_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SRC_W-1:0]     source;
        logic [ADDR_W-1:0]    address;
        logic [DATA_W/8-1:0]  mask;
        logic [DATA_W-1:0]    data;
    } a_beat_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [D_PARAM_W-1:0] param;
        logic [SIZE_W-1:0]    size;
        logic [SRC_W-1:0]     source;
        logic                 denied;
        logic [DATA_W-1:0]    data;
        logic                 corrupt;
    } d_beat_t;

    a_beat_t a_in_beat;
    a_beat_t a_out_beat;
    d_beat_t d_in_beat;
    d_beat_t d_out_beat;

    tl_link_buffer_if #(.WIDTH(A_W)) a_enq ();
    tl_link_buffer_if #(.WIDTH(A_W)) a_deq ();
    tl_link_buffer_if #(.WIDTH(D_W)) d_enq ();
    tl_link_buffer_if #(.WIDTH(D_W)) d_deq ();

    // A channel: master -> slave.
    assign a_in_beat   = a_beat_t'(in_a_bits);
    assign a_enq.valid = in_a_valid;
    assign a_enq.bits  = a_in_beat;
    assign in_a_ready  = a_enq.ready;

    assign a_out_beat  = a_beat_t'(a_deq.bits);
    assign out_a_valid = a_deq.valid;
    assign out_a_bits  = a_out_beat;
    assign a_deq.ready = out_a_ready;

    // D channel: slave -> master.
    assign d_in_beat   = d_beat_t'(in_d_bits);
    assign d_enq.valid = in_d_valid;
    assign d_enq.bits  = d_in_beat;
    assign in_d_ready  = d_enq.ready;

    assign d_out_beat  = d_beat_t'(d_deq.bits);
    assign out_d_valid = d_deq.valid;
    assign out_d_bits  = d_out_beat;
    assign d_deq.ready = out_d_ready;

    tl_queue #(
        .WIDTH (A_W),
        .DEPTH (A_DEPTH),
        .FLOW  (A_FLOW),
        .PIPE  (A_PIPE)
    ) u_a_queue (
        .clock (clock),
        .reset (reset),
        .enq   (a_enq),
        .deq   (a_deq),
        .count (a_count)
    );

    tl_queue #(
        .WIDTH (D_W),
        .DEPTH (D_DEPTH),
        .FLOW  (D_FLOW),
        .PIPE  (D_PIPE)
    ) u_d_queue (
        .clock (clock),
        .reset (reset),
        .enq   (d_enq),
        .deq   (d_deq),
        .count (d_count)
    );

endmodule

// File: tb/tb_tl_link_buffer.sv
// Bench for tl_link_buffer: dut0 is a plain depth-2 A / depth-3 D buffer, dut1 has a
// flow+pipe A queue and a zero-depth D channel.
module tb_tl_link_buffer;
    import tl_pkg::*;

    localparam int AW = a_w(32, 32, 1);
    localparam int DW = d_w(32, 1);

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    tl_link_buffer_if #(.WIDTH(AW)) a_in0 ();
    tl_link_buffer_if #(.WIDTH(AW)) a_out0 ();
    tl_link_buffer_if #(.WIDTH(DW)) d_in0 ();
    tl_link_buffer_if #(.WIDTH(DW)) d_out0 ();
    tl_link_buffer_if #(.WIDTH(AW)) a_in1 ();
    tl_link_buffer_if #(.WIDTH(AW)) a_out1 ();
    tl_link_buffer_if #(.WIDTH(DW)) d_in1 ();
    tl_link_buffer_if #(.WIDTH(DW)) d_out1 ();

    logic [1:0] a_count0;
    logic [1:0] d_count0;
    logic [1:0] a_count1;
    logic [0:0] d_count1;

    tl_link_buffer #(
        .A_DEPTH(2), .D_DEPTH(3), .A_FLOW(1'b0), .D_FLOW(1'b0), .A_PIPE(1'b0), .D_PIPE(1'b0)
    ) dut0 (
        .clock(clock), .reset(reset),
        .in_a_valid(a_in0.valid), .in_a_ready(a_in0.ready), .in_a_bits(a_in0.bits),
        .out_a_valid(a_out0.valid), .out_a_ready(a_out0.ready), .out_a_bits(a_out0.bits),
        .in_d_valid(d_in0.valid), .in_d_ready(d_in0.ready), .in_d_bits(d_in0.bits),
        .out_d_valid(d_out0.valid), .out_d_ready(d_out0.ready), .out_d_bits(d_out0.bits),
        .a_count(a_count0), .d_count(d_count0)
    );

    tl_link_buffer #(
        .A_DEPTH(2), .D_DEPTH(0), .A_FLOW(1'b1), .D_FLOW(1'b1), .A_PIPE(1'b1), .D_PIPE(1'b1)
    ) dut1 (
        .clock(clock), .reset(reset),
        .in_a_valid(a_in1.valid), .in_a_ready(a_in1.ready), .in_a_bits(a_in1.bits),
        .out_a_valid(a_out1.valid), .out_a_ready(a_out1.ready), .out_a_bits(a_out1.bits),
        .in_d_valid(d_in1.valid), .in_d_ready(d_in1.ready), .in_d_bits(d_in1.bits),
        .out_d_valid(d_out1.valid), .out_d_ready(d_out1.ready), .out_d_bits(d_out1.bits),
        .a_count(a_count1), .d_count(d_count1)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- beat builders ----------------
    function automatic logic [AW-1:0] mk_a(logic [2:0] op, logic [31:0] addr, logic [31:0] data);
        tl_a_t b;
        b.opcode  = op;
        b.param   = 3'd0;
        b.size    = 3'd2;
        b.source  = 1'($urandom_range(0, 1));
        b.address = addr;
        b.mask    = 4'hF;
        b.data    = data;
        return b;
    endfunction

    function automatic logic [DW-1:0] mk_d();
        tl_d_t b;
        b.opcode  = ($urandom_range(0, 1) == 0) ? ACCESS_ACK : ACCESS_ACK_DATA;
        b.param   = 2'd0;
        b.size    = 3'd2;
        b.source  = 1'($urandom_range(0, 1));
        b.denied  = 1'($urandom_range(0, 1));
        b.data    = $urandom;
        b.corrupt = 1'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic logic [31:0] addr_of(logic [AW-1:0] bits);
        tl_a_t b;
        b = bits;
        return b.address;
    endfunction

    function automatic logic [31:0] data_of(logic [AW-1:0] bits);
        tl_a_t b;
        b = bits;
        return b.data;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (a_in0.ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", a_in0.ready); end
        checks++; if (a_out0.valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", a_out0.valid); end
        checks++; if (a_count0 !== 2'd0) begin failures++; $display("FAIL rst_a_count: got %0d want 0", a_count0); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (a_in0.ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %b want 1", a_in0.ready); end
        checks++; if (a_out0.valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid: got %b want 0", a_out0.valid); end
        // First beat: Get at 0x1000 enqueued in cycle N, visible in cycle N+1.
        @(negedge clock);
        a_in0.valid  = 1'b1;
        a_in0.bits   = mk_a(GET, 32'h1000, 32'h0);
        a_out0.ready = 1'b1;
        #1;
        checks++; if (a_out0.valid !== 1'b0) begin failures++; $display("FAIL first_same_cycle: out_valid got %b want 0", a_out0.valid); end
        @(negedge clock);
        a_in0.valid = 1'b0;
        #1;
        checks++; if (a_out0.valid !== 1'b1) begin failures++; $display("FAIL first_next_cycle: out_valid got %b want 1", a_out0.valid); end
        checks++; if (addr_of(a_out0.bits) !== 32'h1000) begin failures++; $display("FAIL first_addr: got %h want 00001000", addr_of(a_out0.bits)); end
        checks++; if (a_count0 !== 2'd1) begin failures++; $display("FAIL first_count: got %0d want 1", a_count0); end
        @(negedge clock);
        a_out0.ready = 1'b0;
        #1;
        checks++; if (a_count0 !== 2'd0) begin failures++; $display("FAIL first_drained: got %0d want 0", a_count0); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        bit          taken;
        int          cyc;
        a_out0.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            a_in0.valid = 1'b1;
            a_in0.bits  = mk_a(PUT_FULL, 32'(i * 4), $urandom);
            #1;
            checks++; if (a_in0.ready !== (i < 2)) begin failures++; $display("FAIL bp_ready[%0d]: got %b want %b", i, a_in0.ready, (i < 2)); end
            checks++; if (a_count0 !== 2'(i)) begin failures++; $display("FAIL bp_count[%0d]: got %0d want %0d", i, a_count0, i); end
        end
        @(negedge clock);
        a_out0.ready = 1'b1;
        #1;
        checks++; if (a_in0.ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", a_in0.ready); end
        taken = 1'b0;
        cyc   = 0;
        while (got.size() < 3 && cyc < 20) begin
            if (cyc > 0) begin
                @(negedge clock);
                if (taken) a_in0.valid = 1'b0;
                #1;
            end
            if (a_in0.valid && a_in0.ready) taken = 1'b1;
            if (a_out0.valid) got.push_back(addr_of(a_out0.bits));
            cyc++;
        end
        checks++; if (got.size() !== 3) begin failures++; $display("FAIL bp_beats: got %0d want 3", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== 32'(i * 4)) begin failures++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 32'(i * 4)); end
        end
        @(negedge clock);
        a_in0.valid  = 1'b0;
        a_out0.ready = 1'b0;
        #1;
        checks++; if (a_count0 !== 2'd0 || a_out0.valid !== 1'b0) begin failures++; $display("FAIL bp_empty: count %0d valid %b want 0 0", a_count0, a_out0.valid); end
    endtask

    task automatic test_flow();
        @(negedge clock);
        a_out1.ready = 1'b1;
        a_in1.valid  = 1'b1;
        a_in1.bits   = mk_a(PUT_FULL, 32'h40, 32'hDEADBEEF);
        #1;
        checks++; if (a_out1.valid !== 1'b1) begin failures++; $display("FAIL flow_valid: got %b want 1", a_out1.valid); end
        checks++; if (data_of(a_out1.bits) !== 32'hDEADBEEF) begin failures++; $display("FAIL flow_data: got %h want deadbeef", data_of(a_out1.bits)); end
        checks++; if (a_count1 !== 2'd0) begin failures++; $display("FAIL flow_count: got %0d want 0", a_count1); end
        @(negedge clock);
        a_in1.valid = 1'b0;
        #1;
        checks++; if (a_count1 !== 2'd0 || a_out1.valid !== 1'b0) begin failures++; $display("FAIL flow_after: count %0d valid %b want 0 0", a_count1, a_out1.valid); end
    endtask

    task automatic test_pipe();
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] b;
        a_out1.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            b = mk_a(PUT_PARTIAL, 32'h3000 + 32'(i * 4), $urandom);
            a_in1.valid = 1'b1;
            a_in1.bits  = b;
            #1;
            checks++; if (a_in1.ready !== 1'b1) begin failures++; $display("FAIL pipe_fill_ready[%0d]: got %b want 1", i, a_in1.ready); end
            exp_q.push_back(b);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            b = mk_a(PUT_FULL, 32'h4000 + 32'(i * 4), $urandom);
            a_out1.ready = 1'b1;
            a_in1.valid  = 1'b1;
            a_in1.bits   = b;
            #1;
            checks++; if (a_in1.ready !== 1'b1) begin failures++; $display("FAIL pipe_ready[%0d]: got %b want 1", i, a_in1.ready); end
            checks++; if (a_count1 !== 2'd2) begin failures++; $display("FAIL pipe_count[%0d]: got %0d want 2", i, a_count1); end
            checks++; if (a_out1.valid !== 1'b1 || a_out1.bits !== exp_q[0]) begin failures++; $display("FAIL pipe_out[%0d]: valid %b addr %h want 1 %h", i, a_out1.valid, addr_of(a_out1.bits), addr_of(exp_q[0])); end
            void'(exp_q.pop_front());
            exp_q.push_back(b);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            a_in1.valid = 1'b0;
            #1;
            checks++; if (a_out1.valid !== 1'b1 || a_out1.bits !== exp_q[0]) begin failures++; $display("FAIL pipe_drain[%0d]: valid %b addr %h want 1 %h", i, a_out1.valid, addr_of(a_out1.bits), addr_of(exp_q[0])); end
            void'(exp_q.pop_front());
        end
        @(negedge clock);
        a_out1.ready = 1'b0;
        #1;
        checks++; if (a_count1 !== 2'd0) begin failures++; $display("FAIL pipe_empty: got %0d want 0", a_count1); end
    endtask

    task automatic test_random_d();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] want;
        int            sent;
        int            recv;
        int            cyc;
        bit            taken;
        sent  = 0;
        recv  = 0;
        cyc   = 0;
        taken = 1'b0;
        d_in0.valid = 1'b0;
        while (recv < 1000 && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            if (taken) begin
                d_in0.valid = 1'b0;
                taken = 1'b0;
            end
            if (!d_in0.valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                d_in0.valid = 1'b1;
                d_in0.bits  = mk_d();
            end
            d_out0.ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if (d_count0 !== 2'(exp_q.size())) begin failures++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, d_count0, exp_q.size()); end
            checks++; if (d_in0.ready !== (exp_q.size() < 3)) begin failures++; $display("FAIL rnd_ready @%0d: got %b want %b", cyc, d_in0.ready, (exp_q.size() < 3)); end
            checks++; if (d_out0.valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, d_out0.valid, (exp_q.size() != 0)); end
            if (d_out0.valid && d_out0.ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rnd_spurious @%0d: got beat %h want none", cyc, d_out0.bits);
                end else begin
                    want = exp_q.pop_front();
                    checks++; if (d_out0.bits !== want) begin failures++; $display("FAIL rnd_bits @%0d: got %h want %h", cyc, d_out0.bits, want); end
                end
                recv++;
            end
            if (d_in0.valid && d_in0.ready) begin
                exp_q.push_back(d_in0.bits);
                sent++;
                taken = 1'b1;
            end
        end
        checks++; if (recv !== 1000) begin failures++; $display("FAIL rnd_total: got %0d want 1000", recv); end
        @(negedge clock);
        d_in0.valid  = 1'b0;
        d_out0.ready = 1'b0;
    endtask

    task automatic test_d_wire();
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            d_in1.valid  = 1'($urandom_range(0, 1));
            d_in1.bits   = mk_d();
            d_out1.ready = 1'($urandom_range(0, 1));
            #1;
            checks++; if (d_out1.valid !== d_in1.valid || d_out1.bits !== d_in1.bits) begin failures++; $display("FAIL wire_out[%0d]: valid %b bits %h want %b %h", i, d_out1.valid, d_out1.bits, d_in1.valid, d_in1.bits); end
            checks++; if (d_in1.ready !== d_out1.ready || d_count1 !== 1'b0) begin failures++; $display("FAIL wire_ready[%0d]: ready %b count %0d want %b 0", i, d_in1.ready, d_count1, d_out1.ready); end
        end
        @(negedge clock);
        d_in1.valid  = 1'b0;
        d_out1.ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_out0.ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            a_in0.valid = 1'b1;
            a_in0.bits  = mk_a(PUT_FULL, 32'hAA0 + 32'(i * 4), $urandom);
        end
        @(negedge clock);
        a_in0.valid = 1'b0;
        #1;
        checks++; if (a_count0 !== 2'd2) begin failures++; $display("FAIL mid_fill: got %0d want 2", a_count0); end
        @(negedge clock);
        reset       = 1'b1;
        a_in0.valid = 1'b1;
        a_in0.bits  = mk_a(PUT_FULL, 32'hBAD0, 32'h0);
        #1;
        checks++; if (a_in0.ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %b want 1", a_in0.ready); end
        @(negedge clock);
        reset       = 1'b0;
        a_in0.valid = 1'b0;
        #1;
        checks++; if (a_count0 !== 2'd0) begin failures++; $display("FAIL mid_count: got %0d want 0", a_count0); end
        checks++; if (a_out0.valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b want 0", a_out0.valid); end
        @(negedge clock);
        a_in0.valid = 1'b1;
        a_in0.bits  = mk_a(GET, 32'h2000, 32'h0);
        @(negedge clock);
        a_in0.valid  = 1'b0;
        a_out0.ready = 1'b1;
        #1;
        checks++; if (a_out0.valid !== 1'b1 || addr_of(a_out0.bits) !== 32'h2000) begin failures++; $display("FAIL mid_fresh: valid %b addr %h want 1 00002000", a_out0.valid, addr_of(a_out0.bits)); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            checks++; if (a_out0.valid !== 1'b0) begin failures++; $display("FAIL mid_stale[%0d]: valid %b addr %h want 0", i, a_out0.valid, addr_of(a_out0.bits)); end
        end
        a_out0.ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        a_in0.valid  = 1'b0; a_in0.bits = '0; a_out0.ready = 1'b0;
        d_in0.valid  = 1'b0; d_in0.bits = '0; d_out0.ready = 1'b0;
        a_in1.valid  = 1'b0; a_in1.bits = '0; a_out1.ready = 1'b0;
        d_in1.valid  = 1'b0; d_in1.bits = '0; d_out1.ready = 1'b0;

        test_reset();
        test_backpressure();
        test_flow();
        test_pipe();
        test_random_d();
        test_d_wire();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tl_link_buffer.md
Name: tl_link_buffer

Overview:
Parametrised TileLink-UL link buffer for the A (request) and D (response) channels between a master port and a slave port. It replaces the current zero-latency channel pass-through with independently sized FIFO stages on each channel. Each channel has selectable flow-through and pipe modes, and depth 0 degenerates to a plain wire. It sits on core-to-fabric and fabric-to-peripheral links where timing closure or decoupling is required.

Parameters:
ADDR_W, 32, A-channel address width
DATA_W, 32, data width; mask width is DATA_W/8
SRC_W, 1, source-ID width, A and D
A_DEPTH, 2, A-channel entries; 0 = combinational pass-through
D_DEPTH, 2, D-channel entries; 0 = combinational pass-through
A_FLOW, 0, 1 = an empty A queue forwards input to output in the same cycle
D_FLOW, 0, same for D
A_PIPE, 0, 1 = a full A queue accepts input in the same cycle it is dequeued
D_PIPE, 0, same for D

Ports:
clock  in  1  sole clock; all state updates on its rising edge
reset  in  1  synchronous, active-high
in_a_valid  in  1  master A valid
in_a_ready  out  1  master A ready
in_a_bits  in  A_W  packed {opcode[2:0], param[2:0], size[2:0], source[SRC_W], address[ADDR_W], mask[DATA_W/8], data[DATA_W]}
out_a_valid  out  1  slave A valid
out_a_ready  in  1  slave A ready
out_a_bits  out  A_W  same packing as in_a_bits
in_d_valid  in  1  slave D valid
in_d_ready  out  1  slave D ready
in_d_bits  in  D_W  packed {opcode[2:0], param[1:0], size[2:0], source[SRC_W], denied, data[DATA_W], corrupt}
out_d_valid  out  1  master D valid
out_d_ready  in  1  master D ready
out_d_bits  out  D_W  same packing as in_d_bits
a_count  out  clog2(A_DEPTH+1)  A occupancy
d_count  out  clog2(D_DEPTH+1)  D occupancy

Behaviour:
- Channels are fully independent; the per-channel rules below apply to both.
- Fire = valid & ready on a given side. Enqueue writes the entry at wptr; dequeue presents the entry at rptr.
- Pointers wrap explicitly at DEPTH-1. Non-power-of-2 depths are legal.
- count increments by 1 on enqueue only, decrements by 1 on dequeue only, and is unchanged on both. Never exceeds DEPTH and never underflows.
- out_valid = (count != 0), OR (FLOW & in_valid) when empty.
- out_bits = storage[rptr], OR in_bits when FLOW and empty.
- in_ready = (count != DEPTH), OR (PIPE & out_ready) when full.
- FLOW and empty with out_ready = 1 and in_valid = 1: the beat passes through in the same cycle; count stays 0 and storage is untouched.
- Non-FLOW latency: a beat enqueued in cycle N is visible at out in cycle N+1.
- PIPE and full with out_ready = 1: the enqueue and dequeue in that cycle are both legal; count stays DEPTH.
- Non-PIPE and full: in_ready = 0 regardless of out_ready.
- DEPTH = 0: out = in and in_ready = out_ready, combinationally; count is tied to 0; FLOW/PIPE are ignored.
- Reset (synchronous, active-high):
  - count = 0, pointers = 0, out_valid = 0;
  - in_ready = 1 while reset is asserted and after it deasserts, for DEPTH > 0;
  - out_bits undefined until the first valid beat; storage is not reset.
- Reset mid-operation: all buffered beats are discarded. During reset, beats offered on in are not stored, even though in_ready = 1.
- Ordering is strict FIFO per channel. No reordering and no bits modification; bits are transported opaquely, with no opcode decoding.
- out_valid never deasserts without a dequeue. Bits are stable while out_valid & !out_ready.

Decomposition:
- Shared package tl_pkg holds:
  - opcode constants (PutFull=0, PutPartial=1, Get=4, AccessAck=0, AccessAckData=1);
  - field widths;
  - packed A/D struct typedefs and the A_W/D_W width functions.
- One sub-module, tl_queue (params WIDTH, DEPTH, FLOW, PIPE), instantiated once per channel. The top level only packs, unpacks and wires.

Test Plan:
- Reset, then idle, with A_DEPTH=2: out_a_valid=0, in_a_ready=1, a_count=0; after reset deasserts, first beat Get addr 0x1000 appears at out in cycle N+1.
- out_a_ready held 0 and 3 beats offered (A_DEPTH=2, A_PIPE=0): a_count=2, in_a_ready=0 on the third beat; release out_a_ready and verify the order addr 0x0,0x4,0x8 with no loss.
- A_FLOW=1, empty, out_a_ready=1: beat data 0xDEADBEEF appears at out in the same cycle; a_count stays 0.
- A_PIPE=1, full, out_a_ready=1, in_a_valid=1: in_a_ready=1, a_count stays 2, throughput 1 beat/cycle for 16 cycles.
- D_DEPTH=3 (non-power-of-2) with random valid/ready over 1000 beats: scoreboard matches; pointer wrap is correct; d_count stays ≤3.
- Reset pulsed while A holds 2 beats: next cycle a_count=0, out_a_valid=0; the stale beats never appear.
